// File: rtl/motor_ramp_controller.sv
// Slew-limited duty/direction controller for the elevator motor PWM stage.
// Ramps duty toward the commanded speed, forces ramp-to-zero plus a dead
// interval before any reversal, and clears everything on emergency stop.
module motor_ramp_controller #(
    parameter int unsigned STEP_DIV   = 1000,
    parameter int unsigned STEP       = 4,
    parameter int unsigned DEAD_TICKS = 8,
    parameter int unsigned MAX_DUTY   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_speed,
    input  logic       estop,
    output logic [7:0] duty_cycle,
    output logic       motor_dir,
    output logic       motor_en,
    output logic       busy,
    output logic       at_speed
);

    localparam int unsigned CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);
    localparam logic [7:0]        MAX_D     = 8'(MAX_DUTY);
    localparam logic [7:0]        STEP8     = 8'(STEP);
    localparam logic [8:0]        STEP9     = 9'(STEP);

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DEAD
    } state_e;

    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic              tick;
    state_e            state_q, state_d;
    logic [7:0]        duty_q, duty_d;
    logic              motor_dir_q, motor_dir_d;
    logic [7:0]        tgt_speed_q, tgt_speed_d;
    logic              tgt_dir_q, tgt_dir_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              motor_en_q, busy_q, at_speed_q;

    logic              dir_mismatch;
    logic [7:0]        goal;
    logic [8:0]        sum9, floor9;
    logic [7:0]        duty_up, duty_dn;

    // Ramp-tick prescaler: one-cycle tick each time the counter wraps.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    // Saturating one-step duty moves, computed in 9 bits so nothing wraps.
    always_comb begin
        dir_mismatch = (tgt_dir_q != motor_dir_q);
        goal         = dir_mismatch ? '0 : tgt_speed_q;
        sum9         = {1'b0, duty_q} + STEP9;
        duty_up      = (sum9 > {1'b0, tgt_speed_q}) ? tgt_speed_q : sum9[7:0];
        floor9       = {1'b0, goal} + STEP9;
        duty_dn      = ({1'b0, duty_q} < floor9) ? goal : duty_q - STEP8;
    end

    // Next-state logic: command latch plus ramp FSM, evaluated from registered targets.
    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        motor_dir_d = motor_dir_q;
        tgt_speed_d = tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;
        dead_cnt_d  = dead_cnt_q;

        if (estop) begin
            state_d     = IDLE;
            duty_d      = '0;
            tgt_speed_d = '0;
            dead_cnt_d  = '0;
        end else begin
            if (cmd_valid) begin
                tgt_speed_d = (cmd_speed > MAX_D) ? MAX_D : cmd_speed;
                tgt_dir_d   = cmd_dir;
            end

            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (tgt_speed_q != '0) begin
                        if (dir_mismatch) begin
                            state_d    = DEAD;
                            dead_cnt_d = '0;
                        end else begin
                            state_d = ACCEL;
                        end
                    end
                end
                ACCEL: begin
                    if (dir_mismatch || (tgt_speed_q < duty_q)) begin
                        state_d = DECEL;
                    end else if (duty_q == tgt_speed_q) begin
                        state_d = CRUISE;
                    end else if (tick) begin
                        duty_d = duty_up;
                    end
                end
                CRUISE: begin
                    if (dir_mismatch || (tgt_speed_q < duty_q)) begin
                        state_d = DECEL;
                    end else if (tgt_speed_q > duty_q) begin
                        state_d = ACCEL;
                    end
                end
                DECEL: begin
                    if (!dir_mismatch && (tgt_speed_q > duty_q)) begin
                        state_d = ACCEL;
                    end else if (duty_q == goal) begin
                        if (dir_mismatch) begin
                            state_d    = DEAD;
                            dead_cnt_d = '0;
                        end else if (goal == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = CRUISE;
                        end
                    end else if (tick) begin
                        duty_d = duty_dn;
                    end
                end
                DEAD: begin
                    duty_d = '0;
                    if (tick) begin
                        if (dead_cnt_q == DEAD_LAST) begin
                            dead_cnt_d  = '0;
                            motor_dir_d = tgt_dir_q;
                            state_d     = (tgt_speed_q == '0) ? IDLE : ACCEL;
                        end else begin
                            dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    // State, data and registered status outputs (decoded from the next state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q  <= '0;
            state_q     <= IDLE;
            duty_q      <= '0;
            motor_dir_q <= 1'b0;
            tgt_speed_q <= '0;
            tgt_dir_q   <= 1'b0;
            dead_cnt_q  <= '0;
            motor_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            at_speed_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            duty_q      <= duty_d;
            motor_dir_q <= motor_dir_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            dead_cnt_q  <= dead_cnt_d;
            motor_en_q  <= (state_d != IDLE);
            busy_q      <= (state_d == ACCEL) || (state_d == DECEL) || (state_d == DEAD);
            at_speed_q  <= (state_d == CRUISE);
        end
    end

    assign duty_cycle = duty_q;
    assign motor_dir  = motor_dir_q;
    assign motor_en   = motor_en_q;
    assign busy       = busy_q;
    assign at_speed   = at_speed_q;

endmodule
